dbus_responder: RTL and testbench

Memory-side responder for the core's data bus: accepts load/store requests issued by the memory stage, serves them from an internal byte-writable RAM after a configurable latency, and returns a single-cycle completion handshake. It sits on the far side of the data port from the pipeline and serves as the standalone data memory for core-level simulation and bring-up.

---
 rtl/dbus_responder_pkg.sv | 45 ++++
 rtl/dbus_ram.sv | 30 +++
 rtl/dbus_responder.sv | 119 +++++++++++
 tb/tb_dbus_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_responder_pkg.sv
// Shared types for the data-bus responder: access sizes, FSM states and
// the alignment helper used by the fault check.
package dbus_responder_pkg;

    // Access size encoding, matching the load/store funct3 size field.
    typedef enum logic [2:0] {
        MSIZE_B = 3'd0,
        MSIZE_H = 3'd1,
        MSIZE_W = 3'd2,
        MSIZE_D = 3'd3
    } msize_t;

    localparam logic [2:0] SIZE_BYTE   = 3'd0;
    localparam logic [2:0] SIZE_HALF   = 3'd1;
    localparam logic [2:0] SIZE_WORD   = 3'd2;
    localparam logic [2:0] SIZE_DOUBLE = 3'd3;

    // Request fields as presented by the memory stage.
    typedef struct packed {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    // Response fields returned to the memory stage.
    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
        logic        err;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

    // True when addr is not a multiple of 2^size.
    function automatic logic misaligned(input logic [63:0] addr, input logic [2:0] size);
        return |(addr & ((64'd1 << size) - 64'd1));
    endfunction

endpackage

// File: rtl/dbus_ram.sv
// Single-port DEPTH x 64 RAM with eight byte-enable lanes.
// Read and write share one synchronous port; the read returns the
// pre-write contents of the addressed word. No reset on contents.
module dbus_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [7:0]       we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [63:0]      wdata_i,
    output logic [63:0]      rdata_o
);

    logic [63:0] mem_q [DEPTH];

    // Read-before-write access: rdata_o captures the old word while enabled lanes update.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            rdata_o <= mem_q[addr_i];
            for (int i = 0; i < 8; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_responder.sv
// Memory-side responder for the core data bus. A request is accepted in
// IDLE: the word is read and any write committed at that same edge, then
// the completion handshake is returned LATENCY cycles after the request.
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [7:0]  req_strobe,
    input  logic [63:0] req_data,
    output logic        resp_addr_ok,
    output logic        resp_data_ok,
    output logic [63:0] resp_data,
    output logic        resp_err
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [63:0] LIMIT    = BASE_ADDR + 64'(DEPTH) * 64'd8;
    // WAIT spends CNT_LOAD+1 cycles, so IDLE->...->RESP spans LATENCY edges.
    localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    dresp_state_t      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;

    logic              accept;
    logic              fault;
    logic [63:0]       offset;
    logic [IDX_W-1:0]  word_idx;
    logic [7:0]        ram_we;
    logic [63:0]       ram_rdata;
    logic              unused_offset_bits;

    assign accept   = (state_q == IDLE) && req_valid;
    assign fault    = (req_addr < BASE_ADDR) || (req_addr >= LIMIT) ||
                      misaligned(req_addr, req_size);
    assign offset   = req_addr - BASE_ADDR;
    assign word_idx = offset[IDX_W+2:3];
    // A faulting access must leave memory untouched.
    assign ram_we   = fault ? 8'h00 : req_strobe;

    assign unused_offset_bits = ^{offset[63:IDX_W+3], offset[2:0]};

    dbus_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (accept),
        .we_i    (ram_we),
        .addr_i  (word_idx),
        .wdata_i (req_data),
        .rdata_o (ram_rdata)
    );

    // Control state: FSM, latency counter and captured fault flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and handshake outputs decoded from the state register.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        resp_addr_ok = 1'b0;
        resp_data_ok = 1'b0;
        resp_data    = 64'd0;
        resp_err     = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    err_d = fault;
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d      = IDLE;
                resp_addr_ok = 1'b1;
                resp_data_ok = 1'b1;
                resp_err     = err_q;
                // A faulting access reports zero data, not the RAM word.
                resp_data    = err_q ? 64'd0 : ram_rdata;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: three instances (LATENCY 2, 1 and 5) driven
// by directed transactions, checked cycle by cycle against a timer-based
// transaction model and by hand-computed literal expectations.
module tb_dbus_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    logic        clk;
    logic        rstn [3];
    logic        rv   [3];
    logic [63:0] ra   [3];
    logic [2:0]  rs   [3];
    logic [7:0]  sb   [3];
    logic [63:0] wd   [3];
    logic        aok  [3];
    logic        dok  [3];
    logic [63:0] rdat [3];
    logic        rerr [3];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state
    bit          m_busy   [3];
    bit          m_resp   [3];
    int          m_t      [3];
    logic [63:0] m_data   [3];
    bit          m_err    [3];
    bit          m_dknown [3];
    logic [63:0] mmem     [3][DEPTH];
    bit          mknown   [3][DEPTH];

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(2), .BASE_ADDR(BASE)) u_l2 (
        .clk(clk), .resetn(rstn[0]), .req_valid(rv[0]), .req_addr(ra[0]),
        .req_size(rs[0]), .req_strobe(sb[0]), .req_data(wd[0]),
        .resp_addr_ok(aok[0]), .resp_data_ok(dok[0]), .resp_data(rdat[0]), .resp_err(rerr[0]));

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (
        .clk(clk), .resetn(rstn[1]), .req_valid(rv[1]), .req_addr(ra[1]),
        .req_size(rs[1]), .req_strobe(sb[1]), .req_data(wd[1]),
        .resp_addr_ok(aok[1]), .resp_data_ok(dok[1]), .resp_data(rdat[1]), .resp_err(rerr[1]));

    dbus_responder #(.DEPTH(DEPTH), .LATENCY(5), .BASE_ADDR(BASE)) u_l5 (
        .clk(clk), .resetn(rstn[2]), .req_valid(rv[2]), .req_addr(ra[2]),
        .req_size(rs[2]), .req_strobe(sb[2]), .req_data(wd[2]),
        .resp_addr_ok(aok[2]), .resp_data_ok(dok[2]), .resp_data(rdat[2]), .resp_err(rerr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: an accepted request becomes a pending response due LATENCY-1
    // edges later; memory is updated at acceptance.
    task automatic model_accept(input int d);
        logic [63:0] a;
        bit          flt;
        int          idx;
        a   = ra[d];
        flt = (a < BASE) || (a >= BASE + 64'd8 * 64'(DEPTH)) ||
              ((a % (64'd1 << rs[d])) != 64'd0);
        idx = int'(((a - BASE) >> 3) % 64'(DEPTH));
        if (flt) begin
            m_data[d]   = 64'd0;
            m_dknown[d] = 1'b1;
            m_err[d]    = 1'b1;
        end else begin
            m_data[d]   = mmem[d][idx];
            m_dknown[d] = mknown[d][idx];
            m_err[d]    = 1'b0;
            for (int i = 0; i < 8; i++)
                if (sb[d][i]) mmem[d][idx][8*i +: 8] = wd[d][8*i +: 8];
            if (sb[d] == 8'hFF) mknown[d][idx] = 1'b1;
        end
        m_t[d]    = lat_of(d) - 1;
        m_busy[d] = 1'b1;
        m_resp[d] = (m_t[d] == 0);
    endtask

    initial forever begin
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (!rstn[d]) begin
                m_busy[d] = 1'b0;
                m_resp[d] = 1'b0;
            end else if (m_resp[d]) begin
                m_resp[d] = 1'b0;
                m_busy[d] = 1'b0;
            end else if (m_busy[d]) begin
                m_t[d]--;
                if (m_t[d] == 0) m_resp[d] = 1'b1;
            end else if (rv[d]) begin
                model_accept(d);
            end
        end
    end

    // Compare every instance against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rstn[d] && m_resp[d]) begin
                chk($sformatf("model_ctl[%0d]", d), {61'd0, aok[d], dok[d], rerr[d]},
                    {61'd0, 1'b1, 1'b1, m_err[d]});
                if (m_dknown[d])
                    chk($sformatf("model_data[%0d]", d), rdat[d], m_data[d]);
            end else begin
                chk($sformatf("model_idle_ctl[%0d]", d), {61'd0, aok[d], dok[d], rerr[d]}, 64'd0);
                chk($sformatf("model_idle_data[%0d]", d), rdat[d], 64'd0);
            end
        end
    end

    // One complete transaction; holds req_valid until resp_data_ok.
    task automatic do_txn(input int d, input logic [63:0] a, input logic [2:0] sz,
                          input logic [7:0] strb, input logic [63:0] dat,
                          output logic [63:0] rd, output logic er, output int lat);
        bit got;
        got = 1'b0;
        rv[d] = 1'b1; ra[d] = a; rs[d] = sz; sb[d] = strb; wd[d] = dat;
        lat = -1; rd = 64'd0; er = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            lat++;
            if (dok[d]) begin
                got = 1'b1;
                break;
            end
        end
        chk($sformatf("resp_seen[%0d]", d), {63'd0, got}, 64'd1);
        rd = rdat[d];
        er = rerr[d];
        @(posedge clk); #1;
        rv[d] = 1'b0; sb[d] = 8'h00;
    endtask

    // Transaction with literal checks on data (optional), error and latency.
    task automatic txn(input string nm, input int d, input logic [63:0] a, input logic [2:0] sz,
                       input logic [7:0] strb, input logic [63:0] dat,
                       input bit chk_data, input logic [63:0] exp_d, input logic exp_e);
        logic [63:0] rd;
        logic        er;
        int          lat;
        do_txn(d, a, sz, strb, dat, rd, er, lat);
        if (chk_data) chk({nm, "_data"}, rd, exp_d);
        chk({nm, "_err"}, {63'd0, er}, {63'd0, exp_e});
        chk({nm, "_lat"}, 64'(lat), 64'(lat_of(d)));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got_d;
        int          pulses;
        int          t_ok [4];
        bit          seen;

        for (int d = 0; d < 3; d++) begin
            rstn[d] = 1'b0; rv[d] = 1'b0; ra[d] = 64'd0; rs[d] = 3'd0;
            sb[d] = 8'h00; wd[d] = 64'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("reset_outputs[%0d]", d),
                rdat[d] | {61'd0, aok[d], dok[d], rerr[d]}, 64'd0);
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) rstn[d] = 1'b1;
        @(posedge clk); #1;

        // ---------------- LATENCY = 2 instance ----------------
        txn("preload_w0", 0, 64'h8000_0000, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 1'b0);
        txn("load_w0", 0, 64'h8000_0000, 3'd3, 8'h00, 64'd0, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        txn("half_store", 0, 64'h8000_0002, 3'd1, 8'h0C, 64'h0000_0000_BEEF_0000,
            1'b1, 64'h0123_4567_89AB_CDEF, 1'b0);
        txn("load_after_half", 0, 64'h8000_0000, 3'd3, 8'h00, 64'd0, 1'b1, 64'h0123_4567_BEEF_CDEF, 1'b0);
        txn("preload_w1023", 0, 64'h8000_1FF8, 3'd3, 8'hFF, 64'hA5A5_5A5A_1234_5678, 1'b0, 64'd0, 1'b0);
        txn("fault_misalign", 0, 64'h8000_0003, 3'd2, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1);
        txn("fault_below", 0, 64'h7FFF_FFF8, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 64'd0, 1'b1);
        txn("fault_above", 0, 64'h8000_2000, 3'd3, 8'h00, 64'd0, 1'b1, 64'd0, 1'b1);
        txn("w1023_unchanged", 0, 64'h8000_1FF8, 3'd3, 8'h00, 64'd0, 1'b1, 64'hA5A5_5A5A_1234_5678, 1'b0);
        txn("w0_unchanged", 0, 64'h8000_0000, 3'd3, 8'h00, 64'd0, 1'b1, 64'h0123_4567_BEEF_CDEF, 1'b0);
        txn("zero_strobe", 0, 64'h8000_0000, 3'd3, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF,
            1'b1, 64'h0123_4567_BEEF_CDEF, 1'b0);
        txn("after_zero_strobe", 0, 64'h8000_0000, 3'd3, 8'h00, 64'd0, 1'b1, 64'h0123_4567_BEEF_CDEF, 1'b0);

        // req_valid dropped while the transaction is in flight
        rv[0] = 1'b1; ra[0] = 64'h8000_0000; rs[0] = 3'd3; sb[0] = 8'h00; wd[0] = 64'd0;
        @(posedge clk); #1;
        rv[0] = 1'b0;
        pulses = 0; got_d = 64'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dok[0]) begin
                pulses++;
                got_d = rdat[0];
            end
        end
        chk("valid_drop_pulses", 64'(pulses), 64'd1);
        chk("valid_drop_data", got_d, 64'h0123_4567_BEEF_CDEF);
        @(posedge clk); #1;

        // ---------------- LATENCY = 1 instance ----------------
        for (int k = 0; k < 4; k++)
            txn($sformatf("l1_store%0d", k), 1, BASE + 64'(8 * k), 3'd3, 8'hFF,
                64'hC0DE_0000_0000_0000 | 64'(k), 1'b0, 64'd0, 1'b0);
        rv[1] = 1'b1; rs[1] = 3'd3; sb[1] = 8'h00; wd[1] = 64'd0;
        for (int k = 0; k < 4; k++) begin
            ra[1] = BASE + 64'(8 * k);
            seen = 1'b0;
            for (int w = 0; w < 20; w++) begin
                @(negedge clk);
                if (dok[1]) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk($sformatf("b2b_seen%0d", k), {63'd0, seen}, 64'd1);
            t_ok[k] = cyc;
            chk($sformatf("b2b_data%0d", k), rdat[1], 64'hC0DE_0000_0000_0000 | 64'(k));
            @(posedge clk); #1;
        end
        rv[1] = 1'b0;
        for (int k = 1; k < 4; k++)
            chk($sformatf("b2b_interval%0d", k), 64'(t_ok[k] - t_ok[k-1]), 64'd2);
        repeat (3) @(posedge clk);
        #1;

        // ---------------- LATENCY = 5 instance ----------------
        txn("l5_store_w5", 2, 64'h8000_0028, 3'd3, 8'hFF, 64'hFACE_CAFE_0000_0005, 1'b0, 64'd0, 1'b0);
        txn("l5_load_w5", 2, 64'h8000_0028, 3'd3, 8'h00, 64'd0, 1'b1, 64'hFACE_CAFE_0000_0005, 1'b0);
        txn("l5_store_w6", 2, 64'h8000_0030, 3'd3, 8'hFF, 64'h1111_1111_1111_1111, 1'b0, 64'd0, 1'b0);

        // store accepted, then reset while counting down
        rv[2] = 1'b1; ra[2] = 64'h8000_0030; rs[2] = 3'd3; sb[2] = 8'hFF; wd[2] = 64'h0606_0606_0606_0606;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn[2] = 1'b0;
        rv[2] = 1'b0; sb[2] = 8'h00;
        #1;
        chk("rst_wait_outputs", rdat[2] | {61'd0, aok[2], dok[2], rerr[2]}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn[2] = 1'b1;
        txn("persist_after_reset", 2, 64'h8000_0030, 3'd3, 8'h00, 64'd0, 1'b1, 64'h0606_0606_0606_0606, 1'b0);

        // reset asserted during the completion cycle clears outputs at once
        rv[2] = 1'b1; ra[2] = 64'h8000_0028; rs[2] = 3'd3; sb[2] = 8'h00;
        seen = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (dok[2]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_resp_seen", {63'd0, seen}, 64'd1);
        chk("rst_resp_data_before", rdat[2], 64'hFACE_CAFE_0000_0005);
        #1;
        rstn[2] = 1'b0;
        rv[2] = 1'b0;
        #1;
        chk("rst_resp_outputs", rdat[2] | {61'd0, aok[2], dok[2], rerr[2]}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn[2] = 1'b1;
        txn("l5_reload_w5", 2, 64'h8000_0028, 3'd3, 8'h00, 64'd0, 1'b1, 64'hFACE_CAFE_0000_0005, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
